cache_fill_ctrl: RTL and testbench

Parametrised cache miss controller: on a miss it optionally writes back a dirty victim block, then fetches the missing block from memory word by word and commits the tag. It sits between the cache tag-match logic and the memory port, and its busy output serves as the pipeline stall. Generalises the fixed 16-bit/16-byte write-through fill controller with:
- configurable address, data and block widths;
- a valid/ready pipelined memory request port instead of a fixed latency;
- an optional write-back (dirty eviction) mode.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_fill_counter.sv | 41 ++++
 rtl/cache_fill_ctrl.sv | 154 +++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared state encoding and block-geometry helpers for the cache fill controller.
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WB     = 2'd1,
      ST_FILL   = 2'd2,
      ST_COMMIT = 2'd3
   } fill_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 32'sd0;
      while ((32'sd1 << r) < value) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

   function automatic int calc_words(input int block_bytes, input int data_w);
      return block_bytes / (data_w / 32'sd8);
   endfunction

   function automatic int calc_idx_w(input int words);
      return (clog2(words) < 32'sd1) ? 32'sd1 : clog2(words);
   endfunction

endpackage

// File: rtl/cache_fill_counter.sv
// Up-counter with synchronous clear (priority over increment) and a terminal-count flag.
module cache_fill_counter
#(
   parameter int W    = 4,
   parameter int TERM = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins over increment.
   always_comb begin
      if (clr_i) begin
         cnt_d = {W{1'b0}};
      end else if (inc_i) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == W'(TERM));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss controller: optional dirty-victim write-back, word-wise block fill, then tag commit.
module cache_fill_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int BLOCK_BYTES = 16,
   parameter bit WRITE_BACK  = 1'b0,
   localparam int WORDS      = calc_words(BLOCK_BYTES, DATA_W),
   localparam int IDX_W      = calc_idx_w(WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic              victim_dirty,
   input  logic [ADDR_W-1:0] victim_address,
   input  logic [DATA_W-1:0] cache_rd_data,
   output logic              fsm_busy,
   output logic [IDX_W-1:0]  cache_word_idx,
   output logic              write_data_array,
   output logic              write_tag_array,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] memory_data,
   input  logic              memory_data_valid
);

   localparam int CW    = IDX_W + 1;
   localparam int BPW   = DATA_W / 8;
   localparam int OFF_W = clog2(BLOCK_BYTES);
   localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF_W;

   fill_state_e       state_q;
   logic [ADDR_W-1:0] miss_base_q;
   logic [ADDR_W-1:0] victim_base_q;
   logic [ADDR_W-1:0] word_off_s;
   logic [CW-1:0]     iss_s;
   logic [CW-1:0]     rcv_s;
   logic              iss_done_s;
   logic              rcv_last_s;
   logic              iss_clr_s;
   logic              iss_inc_s;
   logic              rcv_clr_s;
   logic              rcv_inc_s;
   logic              wb_last_s;
   logic              fill_last_s;
   logic              unused_mem_data_s;

   // memory_data goes straight to the data array; only the write strobe is produced here.
   assign unused_mem_data_s = ^memory_data;

   assign word_off_s  = ADDR_W'(iss_s[IDX_W-1:0]) * ADDR_W'(BPW);
   assign rcv_inc_s   = (state_q == ST_FILL) && memory_data_valid && (rcv_s != iss_s);
   assign fill_last_s = rcv_inc_s && rcv_last_s;
   assign iss_inc_s   = mem_req && mem_ready;
   assign wb_last_s   = (state_q == ST_WB) && mem_ready && (iss_s == CW'(WORDS - 1));
   assign iss_clr_s   = (state_q == ST_IDLE) || wb_last_s;
   assign rcv_clr_s   = (state_q == ST_IDLE);
   assign fsm_busy    = (state_q != ST_IDLE) || miss_detected;

   cache_fill_counter #(.W(CW), .TERM(WORDS)) u_iss (
      .clk   (clk),
      .rst   (rst),
      .clr_i (iss_clr_s),
      .inc_i (iss_inc_s),
      .cnt_o (iss_s),
      .tc_o  (iss_done_s)
   );

   cache_fill_counter #(.W(CW), .TERM(WORDS - 1)) u_rcv (
      .clk   (clk),
      .rst   (rst),
      .clr_i (rcv_clr_s),
      .inc_i (rcv_inc_s),
      .cnt_o (rcv_s),
      .tc_o  (rcv_last_s)
   );

   // Output decode from registered state and counters.
   always_comb begin
      mem_req          = 1'b0;
      mem_we           = 1'b0;
      mem_addr         = {ADDR_W{1'b0}};
      mem_wdata        = {DATA_W{1'b0}};
      cache_word_idx   = {IDX_W{1'b0}};
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
      case (state_q)
         ST_WB: begin
            mem_req        = 1'b1;
            mem_we         = 1'b1;
            mem_addr       = victim_base_q + word_off_s;
            mem_wdata      = cache_rd_data;
            cache_word_idx = iss_s[IDX_W-1:0];
         end
         ST_FILL: begin
            mem_req = !iss_done_s;
            if (!iss_done_s) begin
               mem_addr = miss_base_q + word_off_s;
            end else begin
               mem_addr = {ADDR_W{1'b0}};
            end
            cache_word_idx   = rcv_s[IDX_W-1:0];
            write_data_array = rcv_inc_s;
         end
         ST_COMMIT: begin
            write_tag_array = 1'b1;
         end
         default: begin
            mem_req = 1'b0;
         end
      endcase
   end

   // Miss FSM with block-aligned address latches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         miss_base_q   <= {ADDR_W{1'b0}};
         victim_base_q <= {ADDR_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (miss_detected) begin
                  miss_base_q   <= miss_address & BASE_MASK;
                  victim_base_q <= WRITE_BACK ? (victim_address & BASE_MASK) : {ADDR_W{1'b0}};
                  state_q       <= (WRITE_BACK && victim_dirty) ? ST_WB : ST_FILL;
               end
            end
            ST_WB: begin
               if (wb_last_s) begin
                  state_q <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (fill_last_s) begin
                  state_q <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench: three controller configurations sharing one memory responder with fixed read latency.
module tb_cache_fill_ctrl;

   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst;
   logic [15:0] miss_address, victim_address, mem_data16, rd_a, rd_b;
   logic [31:0] mem_data32, rd_c;
   logic victim_dirty, mem_ready, mem_valid;
   logic miss_a, miss_b, miss_c;

   logic a_busy, a_wda, a_wta, a_req, a_we;
   logic b_busy, b_wda, b_wta, b_req, b_we;
   logic c_busy, c_wda, c_wta, c_req, c_we;
   logic [2:0]  a_idx, b_idx, c_idx;
   logic [15:0] a_addr, b_addr, c_addr, a_wdata, b_wdata;
   logic [31:0] c_wdata;

   logic s_busy, s_wda, s_wta, s_req, s_we;
   logic [2:0]  s_idx;
   logic [15:0] s_addr;
   logic [31:0] s_wdata;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc;
   int   sel;
   int   rq[$];
   bit   toggle_ready;
   bit   genuine;
   logic [3:0] rpat = 4'b1001;

   always #5 clk = ~clk;

   assign rd_a = 16'h5A5A;
   assign rd_b = 16'hC500 | {13'd0, b_idx};
   assign rd_c = 32'h0000_0000;

   cache_fill_ctrl u_a (
      .clk(clk), .rst(rst), .miss_detected(miss_a), .miss_address(miss_address),
      .victim_dirty(victim_dirty), .victim_address(victim_address), .cache_rd_data(rd_a),
      .fsm_busy(a_busy), .cache_word_idx(a_idx), .write_data_array(a_wda), .write_tag_array(a_wta),
      .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_ready(mem_ready),
      .memory_data(mem_data16), .memory_data_valid(mem_valid)
   );

   cache_fill_ctrl #(.WRITE_BACK(1'b1)) u_b (
      .clk(clk), .rst(rst), .miss_detected(miss_b), .miss_address(miss_address),
      .victim_dirty(victim_dirty), .victim_address(victim_address), .cache_rd_data(rd_b),
      .fsm_busy(b_busy), .cache_word_idx(b_idx), .write_data_array(b_wda), .write_tag_array(b_wta),
      .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_ready(mem_ready),
      .memory_data(mem_data16), .memory_data_valid(mem_valid)
   );

   cache_fill_ctrl #(.DATA_W(32), .BLOCK_BYTES(32)) u_c (
      .clk(clk), .rst(rst), .miss_detected(miss_c), .miss_address(miss_address),
      .victim_dirty(victim_dirty), .victim_address(victim_address), .cache_rd_data(rd_c),
      .fsm_busy(c_busy), .cache_word_idx(c_idx), .write_data_array(c_wda), .write_tag_array(c_wta),
      .mem_req(c_req), .mem_we(c_we), .mem_addr(c_addr), .mem_wdata(c_wdata), .mem_ready(mem_ready),
      .memory_data(mem_data32), .memory_data_valid(mem_valid)
   );

   // View of whichever instance the current scenario drives.
   always_comb begin
      case (sel)
         1: begin
            {s_busy, s_wda, s_wta, s_req, s_we} = {b_busy, b_wda, b_wta, b_req, b_we};
            s_idx = b_idx; s_addr = b_addr; s_wdata = {16'h0000, b_wdata};
         end
         2: begin
            {s_busy, s_wda, s_wta, s_req, s_we} = {c_busy, c_wda, c_wta, c_req, c_we};
            s_idx = c_idx; s_addr = c_addr; s_wdata = c_wdata;
         end
         default: begin
            {s_busy, s_wda, s_wta, s_req, s_we} = {a_busy, a_wda, a_wta, a_req, a_we};
            s_idx = a_idx; s_addr = a_addr; s_wdata = {16'h0000, a_wdata};
         end
      endcase
   end

   // One cycle: drive inputs just after the edge, sample mid-cycle, record accepted reads.
   task automatic step(input bit miss, input bit spurious);
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      miss_a = miss && (sel == 0);
      miss_b = miss && (sel == 1);
      miss_c = miss && (sel == 2);
      mem_ready = toggle_ready ? rpat[(cyc + 3) % 4] : 1'b1;
      genuine = (rq.size() != 0) && (rq[0] == cyc);
      if (genuine) rq.delete(0);
      mem_valid  = genuine || spurious;
      mem_data16 = 16'(cyc) ^ 16'hA5A5;
      mem_data32 = 32'(cyc) ^ 32'h1234_5678;
      @(negedge clk);
      if (s_req && mem_ready && !s_we) rq.push_back(cyc + LAT);
   endtask

   task automatic test_reset();
      rst = 1'b1; sel = 0; toggle_ready = 1'b0;
      {miss_a, miss_b, miss_c, victim_dirty, mem_ready, mem_valid} = 6'b0;
      miss_address = 16'h0000; victim_address = 16'h0000;
      mem_data16 = 16'h0000; mem_data32 = 32'h0;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         sel = k;
         #1;
         n_cmp++;
         if ({s_req, s_we, s_wda, s_wta, s_busy} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctl dut=%0d: got %b want 00000", k, {s_req, s_we, s_wda, s_wta, s_busy});
         end
         n_cmp++;
         if ({s_addr, s_idx, s_wdata} !== 51'h0) begin
            n_err++; $display("FAIL reset_data dut=%0d: got addr=%h idx=%0d wdata=%h want zeros", k, s_addr, s_idx, s_wdata);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0; sel = 0;
   endtask

   // Fill with no victim write, ready=1: reads cycles 1-8, writes 5-12, tag 13, idle 14.
   task automatic test_plain_fill(input string name, input int which, input logic [15:0] miss,
                                  input logic [15:0] base, input int stride);
      logic [4:0]  exp_ctl;
      logic [15:0] exp_addr;
      sel = which; toggle_ready = 1'b0; cyc = -1; rq.delete();
      miss_address = miss;
      for (int c = 0; c <= 14; c++) begin
         step(c == 0, 1'b0);
         exp_ctl  = {(c >= 1 && c <= 8), 1'b0, (c >= 5 && c <= 12), (c == 13), (c <= 13)};
         exp_addr = base + 16'(stride * (c - 1));
         n_cmp++;
         if ({s_req, s_we, s_wda, s_wta, s_busy} !== exp_ctl) begin
            n_err++; $display("FAIL %s ctl c=%0d: got %b want %b (req,we,wr,tag,busy)", name, c, {s_req, s_we, s_wda, s_wta, s_busy}, exp_ctl);
         end
         if (c >= 1 && c <= 8) begin
            n_cmp++;
            if (s_addr !== exp_addr) begin
               n_err++; $display("FAIL %s addr c=%0d: got %h want %h", name, c, s_addr, exp_addr);
            end
         end
         if (c >= 5 && c <= 12) begin
            n_cmp++;
            if (s_idx !== 3'(c - 5)) begin
               n_err++; $display("FAIL %s idx c=%0d: got %0d want %0d", name, c, s_idx, c - 5);
            end
         end
      end
   endtask

   // Dirty victim: writes cycles 1-8, reads 9-16, array writes 13-20, tag 21, idle 22.
   task automatic test_write_back();
      logic [4:0]  exp_ctl;
      logic [15:0] exp_addr;
      bit wb, rd;
      sel = 1; toggle_ready = 1'b0; cyc = -1; rq.delete();
      victim_address = 16'h5678; victim_dirty = 1'b1; miss_address = 16'h1230;
      for (int c = 0; c <= 22; c++) begin
         step(c == 0, 1'b0);
         wb = (c >= 1 && c <= 8);
         rd = (c >= 9 && c <= 16);
         exp_ctl  = {wb || rd, wb, (c >= 13 && c <= 20), (c == 21), (c <= 21)};
         exp_addr = wb ? 16'h5670 + 16'(2 * (c - 1)) : 16'h1230 + 16'(2 * (c - 9));
         n_cmp++;
         if ({s_req, s_we, s_wda, s_wta, s_busy} !== exp_ctl) begin
            n_err++; $display("FAIL wb ctl c=%0d: got %b want %b (req,we,wr,tag,busy)", c, {s_req, s_we, s_wda, s_wta, s_busy}, exp_ctl);
         end
         if (wb || rd) begin
            n_cmp++;
            if (s_addr !== exp_addr) begin
               n_err++; $display("FAIL wb addr c=%0d: got %h want %h", c, s_addr, exp_addr);
            end
         end
         if (wb) begin
            n_cmp++;
            if ({s_idx, s_wdata} !== {3'(c - 1), 32'h0000_C500 + 32'(c - 1)}) begin
               n_err++; $display("FAIL wb wdata c=%0d: got idx=%0d data=%h want idx=%0d data=%h", c, s_idx, s_wdata, c - 1, 32'h0000_C500 + 32'(c - 1));
            end
         end
         if (c >= 13 && c <= 20) begin
            n_cmp++;
            if (s_idx !== 3'(c - 13)) begin
               n_err++; $display("FAIL wb fill_idx c=%0d: got %0d want %0d", c, s_idx, c - 13);
            end
         end
      end
      victim_dirty = 1'b0;
   endtask

   // ready 1,0,0,1 repeating: accepts in 1,4,5,8,9,12,13,16; responses 5..20; tag 21.
   task automatic test_ready_toggle();
      int n_acc, n_rsp;
      logic exp_req;
      logic [4:0] exp_ctl;
      sel = 0; toggle_ready = 1'b1; cyc = -1; rq.delete();
      miss_address = 16'h1234; n_acc = 0; n_rsp = 0;
      for (int c = 0; c <= 22; c++) begin
         step(c == 0, (c <= 1) || (c == 22));
         exp_req = (c >= 1) && (n_acc < 8);
         exp_ctl = {exp_req, 1'b0, genuine, (c == 21), (c <= 21)};
         n_cmp++;
         if ({s_req, s_we, s_wda, s_wta, s_busy} !== exp_ctl) begin
            n_err++; $display("FAIL stall ctl c=%0d: got %b want %b (req,we,wr,tag,busy)", c, {s_req, s_we, s_wda, s_wta, s_busy}, exp_ctl);
         end
         if (exp_req) begin
            n_cmp++;
            if (s_addr !== 16'h1230 + 16'(2 * n_acc)) begin
               n_err++; $display("FAIL stall addr c=%0d: got %h want %h", c, s_addr, 16'h1230 + 16'(2 * n_acc));
            end
         end
         if (genuine) begin
            n_cmp++;
            if (s_idx !== 3'(n_rsp)) begin
               n_err++; $display("FAIL stall idx c=%0d: got %0d want %0d", c, s_idx, n_rsp);
            end
            n_rsp++;
         end
         if (s_req && mem_ready) n_acc++;
      end
      n_cmp++;
      if (n_acc !== 8) begin
         n_err++; $display("FAIL stall read_count: got %0d want 8", n_acc);
      end
      toggle_ready = 1'b0;
   endtask

   // Reset in the FILL cycle after the 3rd response, then a clean refill.
   task automatic test_reset_mid();
      sel = 0; toggle_ready = 1'b0; cyc = -1; rq.delete();
      miss_address = 16'h1234;
      for (int c = 0; c <= 7; c++) step(c == 0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1; rq.delete(); mem_valid = 1'b0;
      #1;
      n_cmp++;
      if ({a_req, a_we, a_wda, a_wta, a_busy} !== 5'b0) begin
         n_err++; $display("FAIL midrst ctl: got %b want 00000", {a_req, a_we, a_wda, a_wta, a_busy});
      end
      n_cmp++;
      if ({a_addr, a_idx, a_wdata} !== 35'h0) begin
         n_err++; $display("FAIL midrst data: got addr=%h idx=%0d wdata=%h want zeros", a_addr, a_idx, a_wdata);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      test_plain_fill("refill", 0, 16'h4440, 16'h4440, 2);
   endtask

   initial begin
      test_reset();
      test_plain_fill("default", 0, 16'h1234, 16'h1230, 2);
      test_write_back();
      test_plain_fill("clean_victim", 1, 16'h1230, 16'h1230, 2);
      test_ready_toggle();
      test_reset_mid();
      test_plain_fill("wide", 2, 16'hFFFA, 16'hFFE0, 4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
